// File: rtl/poly_small_mkgauss_multi.sv
// Small Gaussian polynomial front end: filters sampler output into 1 or 2 odd-sum polynomials
// of degree 2^logn and streams them out through a single valid/ready output register.
module poly_small_mkgauss_multi #(
  parameter int unsigned LOGN_MAX = 10,
  parameter int unsigned COEF_W   = 8,
  parameter int unsigned BOUND    = 127,
  parameter int unsigned RCNT_W   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [3:0]          logn_i,
  input  logic                two_poly_i,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                smp_req,
  input  logic                smp_valid,
  input  logic [31:0]         smp_data,
  output logic                coef_valid,
  input  logic                coef_ready,
  output logic [COEF_W-1:0]   coef_data,
  output logic [LOGN_MAX-1:0] coef_idx,
  output logic                coef_poly,
  output logic                coef_last,
  output logic [RCNT_W-1:0]   rej_cnt
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  localparam int unsigned NW = LOGN_MAX + 1;
  localparam logic signed [31:0] BoundS = 32'(BOUND);

  state_e              state_q;
  logic [3:0]          logn_q;
  logic                two_q;
  logic [LOGN_MAX-1:0] idx_q;
  logic                par_q;
  logic                poly_q;
  logic                busy_q, done_q, err_q;
  logic                cv_q;
  logic [COEF_W-1:0]   data_q;
  logic [LOGN_MAX-1:0] oidx_q;
  logic                opoly_q, olast_q;
  logic [RCNT_W-1:0]   rej_q;

  logic [NW-1:0] n_full, n_m1;
  logic          at_last, in_bound, par_ok, smp_acc, take, reject, final_coef, logn_legal;

  assign n_full     = NW'(1) << logn_q;
  assign n_m1       = n_full - NW'(1);
  assign at_last    = (idx_q == n_m1[LOGN_MAX-1:0]);
  assign in_bound   = ($signed(smp_data) <= BoundS) && ($signed(smp_data) >= -BoundS);
  assign smp_req    = (state_q == StRun) && (!cv_q || coef_ready);
  assign smp_acc    = smp_req && smp_valid;
  // Last coefficient must make the running sum odd.
  assign par_ok     = !at_last || (par_q ^ smp_data[0]);
  assign take       = smp_acc && in_bound && par_ok;
  assign reject     = smp_acc && !take;
  assign final_coef = at_last && (poly_q == two_q);
  assign logn_legal = (logn_i != 4'd0) && (32'(logn_i) <= LOGN_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      logn_q  <= '0;
      two_q   <= 1'b0;
      idx_q   <= '0;
      par_q   <= 1'b0;
      poly_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cv_q    <= 1'b0;
      data_q  <= '0;
      oidx_q  <= '0;
      opoly_q <= 1'b0;
      olast_q <= 1'b0;
      rej_q   <= '0;
    end else begin
      if (take) begin
        cv_q    <= 1'b1;
        data_q  <= smp_data[COEF_W-1:0];
        oidx_q  <= idx_q;
        opoly_q <= poly_q;
        olast_q <= final_coef;
        if (at_last) begin
          idx_q  <= '0;
          par_q  <= 1'b0;
          poly_q <= poly_q ^ two_q;
        end else begin
          idx_q <= idx_q + 1'b1;
          par_q <= par_q ^ smp_data[0];
        end
      end else if (cv_q && coef_ready) begin
        cv_q <= 1'b0;
      end

      if (reject && (rej_q != '1)) begin
        rej_q <= rej_q + 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (start) begin
            rej_q  <= '0;
            logn_q <= logn_i;
            two_q  <= two_poly_i;
            idx_q  <= '0;
            par_q  <= 1'b0;
            poly_q <= 1'b0;
            busy_q <= 1'b1;
            if (logn_legal) begin
              state_q <= StRun;
            end else begin
              state_q <= StDone;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end
          end
        end
        StRun: begin
          if (take && final_coef) state_q <= StDrain;
        end
        StDrain: begin
          if (cv_q && coef_ready) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign coef_valid = cv_q;
  assign coef_data  = data_q;
  assign coef_idx   = oidx_q;
  assign coef_poly  = opoly_q;
  assign coef_last  = olast_q;
  assign rej_cnt    = rej_q;

endmodule

// File: tb/tb_poly_small_mkgauss_multi.sv
// Randomized bench: a sample-list model predicts the coefficient stream and reject count per job;
// every output handshake is scored against it, plus a few hand-computed literal jobs.
module tb_poly_small_mkgauss_multi;
  localparam int LOGN_MAX = 10;
  localparam int COEF_W   = 8;
  localparam int BOUND    = 127;
  localparam int RCNT_W   = 16;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic [3:0]          logn_i = '0;
  logic                two_poly_i = 1'b0;
  logic                busy, done, err, smp_req;
  logic                smp_valid = 1'b0;
  logic [31:0]         smp_data = '0;
  logic                coef_valid;
  logic                coef_ready = 1'b0;
  logic [COEF_W-1:0]   coef_data;
  logic [LOGN_MAX-1:0] coef_idx;
  logic                coef_poly, coef_last;
  logic [RCNT_W-1:0]   rej_cnt;

  poly_small_mkgauss_multi #(
    .LOGN_MAX(LOGN_MAX), .COEF_W(COEF_W), .BOUND(BOUND), .RCNT_W(RCNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .logn_i(logn_i), .two_poly_i(two_poly_i),
    .busy(busy), .done(done), .err(err), .smp_req(smp_req), .smp_valid(smp_valid),
    .smp_data(smp_data), .coef_valid(coef_valid), .coef_ready(coef_ready),
    .coef_data(coef_data), .coef_idx(coef_idx), .coef_poly(coef_poly),
    .coef_last(coef_last), .rej_cnt(rej_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {int data; int idx; bit poly; bit last;} coef_t;

  coef_t exp_q[$];
  int    samples[$];
  int    obs[$];
  int    obs_poly[$];
  int    sptr, n_vec, n_err, cyc;
  int    exp_rej, exp_used;
  int    v_mode, r_mode;
  bit    tog, inj_en, prev_stall, done_seen, cv_any;
  logic [19:0] prev_coef;
  int    last_hs_cyc, done_cyc, start_cyc;
  bit    done_err, busy_s, done_s;
  int    done_rej;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic int rand_sample();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) begin
      case ($urandom_range(0, 2))
        0: return int'(32'h8000_0000);
        1: return int'($urandom());
        default: return ($urandom_range(0, 1) != 0) ? BOUND + 1 : -(BOUND + 1);
      endcase
    end
    return int'($urandom_range(0, 2 * BOUND + 40)) - (BOUND + 20);
  endfunction

  // Walk the sample list in order applying the bound and odd-sum rules.
  task automatic build_model(input int logn, input bit two);
    int k, n, sum, s;
    bit ok;
    k = 0;
    n = 1 << logn;
    exp_q.delete();
    exp_rej = 0;
    for (int p = 0; p <= (two ? 1 : 0); p++) begin
      sum = 0;
      for (int i = 0; i < n; i++) begin
        ok = 0;
        while (!ok) begin
          if (k >= samples.size()) samples.push_back(rand_sample());
          s = samples[k];
          k++;
          if (s > BOUND || s < -BOUND) exp_rej++;
          else if (i == n - 1 && ((sum + s) % 2) == 0) exp_rej++;
          else begin
            ok = 1;
            sum += s;
            exp_q.push_back('{s, i, bit'(p), (i == n - 1) && (p == (two ? 1 : 0))});
          end
        end
      end
    end
    exp_used = k;
    if (exp_rej > 65535) exp_rej = 65535;
  endtask

  task automatic cycle();
    coef_t e;
    @(negedge clk);
    cyc++;
    busy_s = busy;
    done_s = done;
    if (coef_valid) cv_any = 1;
    if (prev_stall)
      chk("coef_hold", 64'({coef_valid, coef_data, coef_idx, coef_poly, coef_last}),
          64'({1'b1, prev_coef}));
    if (smp_req) chk("smp_req_rule", 64'({busy, !coef_valid || coef_ready}), 64'(2'b11));
    if (coef_valid && coef_ready) begin
      if (exp_q.size() == 0) begin
        chk("coef_extra", 64'(coef_idx), 64'hffff_ffff);
      end else begin
        e = exp_q.pop_front();
        chk("coef", 64'({coef_data, coef_idx, coef_poly, coef_last}),
            64'({e.data[COEF_W-1:0], e.idx[LOGN_MAX-1:0], e.poly, e.last}));
      end
      obs.push_back(int'($signed(coef_data)));
      obs_poly.push_back(int'(coef_poly));
      if (coef_last) last_hs_cyc = cyc;
    end
    if (done && !done_seen) begin
      done_seen = 1;
      done_cyc  = cyc;
      done_err  = err;
      done_rej  = int'(rej_cnt);
    end
    prev_stall = coef_valid && !coef_ready;
    prev_coef  = {coef_data, coef_idx, coef_poly, coef_last};
    if (smp_req && smp_valid) sptr++;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (inj_en && !done_seen && $urandom_range(0, 15) == 0) begin
      start = 1'b1;
      logn_i = 4'($urandom_range(0, 15));
      two_poly_i = 1'($urandom_range(0, 1));
    end
    smp_valid  = (v_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
    smp_data   = (sptr < samples.size()) ? 32'(samples[sptr]) : $urandom();
    coef_ready = (r_mode == 0) ? 1'b1 : (r_mode == 1) ? tog : ($urandom_range(0, 2) != 0);
    tog = ~tog;
  endtask

  task automatic chk_reset(input string name);
    chk(name, 64'({busy, done, err, smp_req, coef_valid, coef_data, coef_idx, coef_poly,
                   coef_last, rej_cnt}), 64'(0));
  endtask

  task automatic run_job(input int logn, input bit two, input int vm, input int rm,
                         input int abort_after);
    bit legal;
    int guard;
    legal = (logn >= 1) && (logn <= LOGN_MAX);
    v_mode = vm;
    r_mode = rm;
    if (legal) build_model(logn, two);
    else begin
      exp_q.delete();
      exp_rej = 0;
      exp_used = 0;
    end
    sptr = 0;
    obs.delete();
    obs_poly.delete();
    done_seen = 0;
    cv_any = 0;
    last_hs_cyc = -1;
    prev_stall = 0;
    start_cyc = cyc;
    start = 1'b1;
    logn_i = 4'(logn);
    two_poly_i = two;
    smp_data = (samples.size() > 0) ? 32'(samples[0]) : 32'd0;
    cycle();
    cycle();
    chk("busy_after_start", 64'(busy_s), 64'(1));
    inj_en = legal;
    guard = 0;
    if (abort_after > 0) begin
      while (obs.size() < abort_after && guard < 20000) begin
        cycle();
        guard++;
      end
      inj_en = 0;
      chk("abort_reach", 64'(obs.size() >= abort_after), 64'(1));
      rst_n = 1'b0;
      #1;
      chk_reset("abort_reset_outputs");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      exp_q.delete();
      prev_stall = 0;
      return;
    end
    while (!done_seen && guard < 40000) begin
      cycle();
      guard++;
    end
    inj_en = 0;
    if (!done_seen) begin
      chk("done_timeout", 64'(0), 64'(1));
      return;
    end
    chk("err", 64'(done_err), 64'(!legal));
    chk("rej_cnt", 64'(done_rej), 64'(exp_rej));
    chk("coef_missing", 64'(exp_q.size()), 64'(0));
    chk("samples_used", 64'(sptr), 64'(exp_used));
    if (legal) chk("done_latency", 64'(done_cyc), 64'(last_hs_cyc + 1));
    else begin
      chk("illegal_done_latency", 64'(done_cyc), 64'(start_cyc + 2));
      chk("illegal_no_coef", 64'(cv_any), 64'(0));
    end
    cycle();
    chk("done_pulse", 64'({done_s, busy_s}), 64'(0));
  endtask

  function automatic int obs_at(input int i);
    return (obs.size() > i) ? obs[i] : 32'h0bad_0bad;
  endfunction

  initial begin
    int sf, sg;
    n_vec = 0;
    n_err = 0;
    cyc = 0;
    tog = 1;
    inj_en = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset_outputs");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    samples = '{3, 4};
    run_job(1, 0, 0, 0, 0);
    chk("t1_size", 64'(obs.size()), 64'(2));
    chk("t1_c0", 64'(obs_at(0)), 64'(3));
    chk("t1_c1", 64'(obs_at(1)), 64'(4));

    samples = '{2, 4, 1};
    run_job(1, 0, 0, 0, 0);
    chk("t2_c0", 64'(obs_at(0)), 64'(2));
    chk("t2_c1", 64'(obs_at(1)), 64'(1));
    chk("t2_rej", 64'(done_rej), 64'(1));

    samples = '{200, -128, 5, -127, 2, 1};
    run_job(2, 0, 1, 2, 0);
    chk("t3_c0", 64'(obs_at(0)), 64'(5));
    chk("t3_c1", 64'(obs_at(1)), 64'(-127));
    chk("t3_rej", 64'(done_rej), 64'(2));

    samples.delete();
    run_job(2, 1, 0, 1, 0);
    chk("t4_count", 64'(obs.size()), 64'(8));
    sf = 0;
    sg = 0;
    foreach (obs[i]) begin
      if (obs_poly[i] == 0) sf += obs[i];
      else sg += obs[i];
    end
    chk("t4_f_odd", 64'(sf % 2 != 0), 64'(1));
    chk("t4_g_odd", 64'(sg % 2 != 0), 64'(1));

    samples.delete();
    run_job(0, 1, 0, 0, 0);
    run_job(LOGN_MAX + 1, 0, 0, 0, 0);

    samples.delete();
    run_job(3, 1, 1, 2, 3);
    chk_reset("post_abort_outputs");
    samples.delete();
    run_job(2, 0, 1, 2, 0);

    for (int j = 0; j < 8; j++) begin
      samples.delete();
      run_job(int'($urandom_range(1, 8)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 0);
    end
    samples.delete();
    run_job(LOGN_MAX, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
